// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and sizing helpers for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    function automatic int unsigned widthOf(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO pop side and UART line bundle for fifo_uart_tx.
interface fifo_uart_tx_if #(
    parameter int unsigned bitWidth = 32
);
    logic                txEnable;
    logic                fifoEmpty;
    logic [bitWidth-1:0] fifoPopData;
    logic                fifoPop;
    logic                txd;
    logic                busy;

    modport master (
        output txEnable, fifoEmpty, fifoPopData,
        input  fifoPop, txd, busy
    );

    modport slave (
        input  txEnable, fifoEmpty, fifoPopData,
        output fifoPop, txd, busy
    );
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period counter: counts 0..clocksPerBit-1, wraps, flags the last count.
module uart_bit_timer
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned clocksPerBit = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tc
);
    localparam int unsigned CW = widthOf(clocksPerBit);
    localparam logic [CW-1:0] LAST = CW'(clocksPerBit - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == LAST);
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO and sends them as 8N1 frames, LSB byte first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned bitWidth     = 32,
    parameter int unsigned clocksPerBit = 434
) (
    input  logic           clock,
    input  logic           reset,
    fifo_uart_tx_if.slave  bus
);
    localparam int unsigned bytesPerWord = bitWidth / 8;
    localparam int unsigned BW = widthOf(bytesPerWord);
    localparam logic [BW-1:0] LAST_BYTE = BW'(bytesPerWord - 1);

    state_t              state;
    logic [bitWidth-1:0] word;
    logic [BW-1:0]       byteIndex;
    logic [2:0]          bitIndex;
    logic                txdReg;
    logic                tc;
    logic                timerClear;
    logic [7:0]          curByte;
    logic                canPop;

    // Timer only runs while a frame is on the line; idle states hold it at 0.
    assign timerClear = !(state inside {START, DATA, STOP});
    assign curByte    = word[8*int'(byteIndex) +: 8];
    assign canPop     = bus.txEnable && !bus.fifoEmpty;

    uart_bit_timer #(
        .clocksPerBit(clocksPerBit)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .clear(timerClear),
        .tc   (tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            word      <= '0;
            byteIndex <= '0;
            bitIndex  <= '0;
            txdReg    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (canPop) state <= POP;
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    word      <= bus.fifoPopData;
                    byteIndex <= '0;
                    txdReg    <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (tc) begin
                        bitIndex <= '0;
                        txdReg   <= curByte[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (tc) begin
                        if (bitIndex == 3'd7) begin
                            txdReg <= 1'b1;
                            state  <= STOP;
                        end else begin
                            bitIndex <= bitIndex + 3'd1;
                            txdReg   <= curByte[bitIndex + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (tc) begin
                        if (byteIndex != LAST_BYTE) begin
                            byteIndex <= byteIndex + BW'(1);
                            txdReg    <= 1'b0;
                            state     <= START;
                        end else if (canPop) begin
                            state <= POP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    txdReg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.txd     = txdReg;
    assign bus.fifoPop = (state == POP);
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, UART receiver scoreboard, corner sequences.
module tb_fifo_uart_tx;
    localparam int unsigned W   = 32;
    localparam int unsigned CPB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fifo_uart_tx_if #(.bitWidth(W)) bus ();

    fifo_uart_tx #(
        .bitWidth    (W),
        .clocksPerBit(CPB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] fifoQ[$];
    logic [7:0]   expQ[$];
    int popCycs[$];
    int startCycs[$];
    int endCycs[$];
    int pops, frames, busyCyc, txdLow;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: data appears the cycle after the pop strobe
    always @(negedge clock) begin
        if (!reset && bus.fifoPop) begin
            logic [W-1:0] w;
            pops++;
            popCycs.push_back(cyc);
            checks++;
            if (fifoQ.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty: got pop at cycle %0d expected none", cyc);
                w = '0;
            end else begin
                w = fifoQ.pop_front();
            end
            bus.fifoEmpty = (fifoQ.size() == 0);
            @(posedge clock);
            #1 bus.fifoPopData = w;
        end
    end

    // UART receiver checking every frame against the scoreboard
    bit       rxActive = 0;
    bit       rxOk;
    int       rxCnt;
    logic [7:0] rxData;

    always @(negedge clock) begin
        if (reset) begin
            rxActive = 0;
        end else begin
            if (bus.busy) busyCyc++;
            if (bus.txd === 1'b0) txdLow++;
            if (!rxActive) begin
                if (bus.txd === 1'b0) begin
                    rxActive = 1;
                    rxOk = 1;
                    rxCnt = 1;
                    rxData = '0;
                    startCycs.push_back(cyc);
                end
            end else begin
                int slot, ph;
                slot = rxCnt / CPB;
                ph = rxCnt % CPB;
                if (slot == 0) begin
                    if (bus.txd !== 1'b0) rxOk = 0;
                end else if (slot <= 8) begin
                    if (ph == 0) rxData[slot-1] = bus.txd;
                    else if (bus.txd !== rxData[slot-1]) rxOk = 0;
                end else begin
                    if (bus.txd !== 1'b1) rxOk = 0;
                end
                rxCnt++;
                if (rxCnt == 10 * CPB) begin
                    rxActive = 0;
                    frames++;
                    endCycs.push_back(cyc);
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("FAIL rx_frame: got byte %02h expected no frame", rxData);
                    end else begin
                        logic [7:0] e;
                        e = expQ.pop_front();
                        if (!rxOk || rxData !== e) begin
                            errors++;
                            $display("FAIL rx_frame: got byte %02h framing_ok %0d expected %02h",
                                     rxData, rxOk, e);
                        end
                    end
                end
            end
        end
    end

    task automatic clearStats();
        pops = 0; frames = 0; busyCyc = 0; txdLow = 0;
        popCycs.delete(); startCycs.delete(); endCycs.delete();
    endtask

    task automatic push(input logic [W-1:0] w);
        logic [W-1:0] t;
        fifoQ.push_back(w);
        bus.fifoEmpty = 1'b0;
        t = w;
        for (int b = 0; b < W / 8; b++) expQ.push_back(t[8*b +: 8]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic waitIdle(input string name, input int maxCyc);
        bit seen = 0;
        bit done = 0;
        for (int i = 0; i < maxCyc && !done; i++) begin
            tick(1);
            if (bus.busy) seen = 1;
            else if (seen) done = 1;
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got still busy expected idle within %0d", name, maxCyc);
        end
    endtask

    task automatic waitFrames(input string name, input int n, input int maxCyc);
        int i = 0;
        while (frames < n && i < maxCyc) begin
            tick(1);
            i++;
        end
        if (frames < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d frames expected %0d", name, frames, n);
        end
    endtask

    typedef struct {
        logic [W-1:0] word;
        int expPops;
        int expBusy;
        int expFrames;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int t;
        vecs[0] = '{32'hA55A0F31, 1, 2 + 160, 4};
        vecs[1] = '{32'h00000000, 1, 2 + 160, 4};
        vecs[2] = '{32'hFFFFFFFF, 1, 2 + 160, 4};
        vecs[3] = '{32'h12345678, 1, 2 + 160, 4};

        bus.txEnable = 1'b0;
        bus.fifoEmpty = 1'b1;
        bus.fifoPopData = '0;
        clearStats();
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_txd", bus.txd, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_pop", bus.fifoPop, 0);

        // FIFO empty, transmitter enabled: nothing happens
        bus.txEnable = 1'b1;
        clearStats();
        tick(100);
        check("empty_pops", pops, 0);
        check("empty_busy", busyCyc, 0);
        check("empty_txd_low", txdLow, 0);

        foreach (vecs[k]) begin
            clearStats();
            t = cyc;
            push(vecs[k].word);
            waitIdle("vec", 400);
            check("vec_pops", pops, vecs[k].expPops);
            check("vec_busy", busyCyc, vecs[k].expBusy);
            check("vec_frames", frames, vecs[k].expFrames);
            check("vec_pop_latency", popCycs.size() > 0 ? popCycs[0] - t : -1, 1);
            check("vec_start_latency", startCycs.size() > 0 ? startCycs[0] - t : -1, 3);
            check("vec_byte_gap", startCycs.size() > 1 ? startCycs[1] - endCycs[0] : -1, 1);
            check("vec_exp_left", expQ.size(), 0);
        end

        // Back-to-back words
        clearStats();
        push(32'h00000001);
        push(32'h80000000);
        waitIdle("b2b", 800);
        tick(20);
        check("b2b_pops", pops, 2);
        check("b2b_frames", frames, 8);
        check("b2b_busy", busyCyc, 2 * 162);
        check("b2b_pop2", popCycs.size() > 1 ? popCycs[1] - endCycs[3] : -1, 1);
        check("b2b_gap", startCycs.size() > 4 ? startCycs[4] - endCycs[3] : -1, 3);
        check("b2b_exp_left", expQ.size(), 0);

        // txEnable dropped mid-word with FIFO non-empty
        clearStats();
        push(32'hCAFEBABE);
        push(32'h5A5AC3C3);
        waitFrames("dis", 2, 200);
        bus.txEnable = 1'b0;
        waitIdle("dis", 400);
        tick(10);
        check("dis_pops", pops, 1);
        check("dis_frames", frames, 4);
        check("dis_busy", bus.busy, 0);
        t = cyc;
        bus.txEnable = 1'b1;
        waitIdle("dis2", 400);
        check("dis_resume_pops", pops, 2);
        check("dis_resume_lat", popCycs.size() > 1 ? popCycs[1] - t : -1, 1);
        check("dis_frames2", frames, 8);
        check("dis_exp_left", expQ.size(), 0);

        // Asynchronous reset in the middle of the second byte
        clearStats();
        push(32'h0F0F0F0F);
        waitFrames("rst", 1, 200);
        tick(8);
        check("rst_busy_before", bus.busy, 1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_txd_now", bus.txd, 1);
        check("rst_busy_now", bus.busy, 0);
        check("rst_pop_now", bus.fifoPop, 0);
        tick(2);
        expQ.delete();
        reset = 1'b0;
        clearStats();
        tick(30);
        check("rst_idle_pops", pops, 0);
        check("rst_idle_busy", busyCyc, 0);
        check("rst_idle_txd", txdLow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
